// File: rtl/spi_tx_scheduler.sv
// ---------------------------------------------------------------------------
// spi_tx_scheduler
//
// Arbitrates up to four requester channels onto a single SPI slave transmit
// word. A granted request is staged into TX_WORD one cycle after it is seen,
// held stable for the whole SPI frame, and acknowledged only after the frame
// completes. When nothing is staged at frame start the idle word is sent and
// the frame is counted as an underrun. An aborted data frame keeps the word
// staged so it is retransmitted on the next frame.
//
// Ports
//   CLK          : single clock
//   RST          : synchronous active-high reset
//   REQ_VALID    : per-channel request, held with data until its ACK
//   REQ_DATA     : per-channel 29-bit payload, channel i at [29*i+28:29*i]
//   REQ_ACK      : one-cycle pulse when the channel's word has been sent
//   FRAME_START  : CS_n fall pulse; the slave captures TX_WORD this cycle
//   FRAME_END    : pulse after a complete 32-bit frame
//   FRAME_ABORT  : pulse when CS_n rose before 32 bits
//   TX_WORD      : word presented to the SPI slave shift register
//   BUSY         : high while a frame is in progress
//   FRAME_CNT    : completed data frames (saturating)
//   UNDERRUN_CNT : completed idle frames (saturating)
//   ABORT_CNT    : aborted frames of either kind (saturating)
//   PROTO_ERR    : sticky flag for out-of-order frame events
//   ERR_CLR      : clears PROTO_ERR
// ---------------------------------------------------------------------------
module spi_tx_scheduler #(
  parameter int          NCH       = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    REQ_VALID,
  input  logic [NCH*29-1:0] REQ_DATA,
  output logic [NCH-1:0]    REQ_ACK,
  input  logic              FRAME_START,
  input  logic              FRAME_END,
  input  logic              FRAME_ABORT,
  output logic [31:0]       TX_WORD,
  output logic              BUSY,
  output logic [15:0]       FRAME_CNT,
  output logic [15:0]       UNDERRUN_CNT,
  output logic [15:0]       ABORT_CNT,
  output logic              PROTO_ERR,
  input  logic              ERR_CLR
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    STAGED    = 2'd1,
    BUSY_DATA = 2'd2,
    BUSY_IDLE = 2'd3
  } state_t;

  // Saturating 16-bit increment shared by all statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t      state_q;
  logic [31:0] tx_word_q;
  logic [1:0]  grant_q;      // channel owning the staged word
  logic [1:0]  rr_ptr_q;     // last acknowledged channel
  logic [3:0]  ack_q;        // padded to four channels, upper bits stay zero
  logic        busy_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] underrun_cnt_q;
  logic [15:0] abort_cnt_q;
  logic        proto_err_q;

  logic [3:0]  valid_pad_s;
  logic [3:0]  elig_s;
  logic [28:0] data_a_s [4];
  logic [2:0]  cand_s;
  logic        grant_found_s;
  logic [1:0]  grant_ch_s;
  logic        violation_s;

  // Per-channel payload slices, padded to four entries so the grant index is
  // always a plain two-bit select regardless of NCH.
  for (genvar g = 0; g < 4; g++) begin : g_data
    if (g < NCH) begin : g_used
      assign data_a_s[g] = REQ_DATA[29*g +: 29];
    end else begin : g_unused
      assign data_a_s[g] = 29'd0;
    end
  end

  // Eligible requesters: a channel being acknowledged this cycle still has its
  // REQ_VALID high (the requester has not seen the ACK yet), so mask it.
  always_comb begin
    valid_pad_s              = 4'b0000;
    valid_pad_s[NCH-1:0]     = REQ_VALID;
    elig_s                   = valid_pad_s & ~ack_q;
  end

  // Round-robin search starting one past the last acknowledged channel.
  always_comb begin
    grant_found_s = 1'b0;
    grant_ch_s    = 2'b00;
    cand_s        = 3'd0;
    for (int k = 1; k <= NCH; k++) begin
      cand_s = {1'b0, rr_ptr_q} + 3'(k);
      if (cand_s >= 3'(NCH)) begin
        cand_s = cand_s - 3'(NCH);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && elig_s[cand_s[1:0]]) begin
        grant_found_s = 1'b1;
        grant_ch_s    = cand_s[1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Frame events that do not fit the current state; they are ignored by the
  // FSM and only raise the sticky error flag.
  always_comb begin
    if (state_q == BUSY_DATA || state_q == BUSY_IDLE) begin
      violation_s = FRAME_START;
    end else begin
      violation_s = FRAME_END | FRAME_ABORT;
    end
  end

  // Scheduler FSM, staging register, acknowledge pulse and statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= EMPTY;
      tx_word_q      <= IDLE_WORD;
      grant_q        <= 2'b00;
      rr_ptr_q       <= 2'(NCH - 1);
      ack_q          <= 4'b0000;
      busy_q         <= 1'b0;
      frame_cnt_q    <= 16'd0;
      underrun_cnt_q <= 16'd0;
      abort_cnt_q    <= 16'd0;
      proto_err_q    <= 1'b0;
    end else begin
      ack_q <= 4'b0000;

      // A new violation outranks a simultaneous clear.
      if (violation_s) begin
        proto_err_q <= 1'b1;
      end else if (ERR_CLR) begin
        proto_err_q <= 1'b0;
      end

      case (state_q)
        EMPTY: begin
          if (FRAME_START) begin
            // Slave captured the idle word; frame carries no data.
            state_q <= BUSY_IDLE;
            busy_q  <= 1'b1;
          end else if (grant_found_s) begin
            state_q   <= STAGED;
            grant_q   <= grant_ch_s;
            tx_word_q <= {1'b1, grant_ch_s, data_a_s[grant_ch_s]};
          end
        end

        STAGED: begin
          if (FRAME_START) begin
            state_q <= BUSY_DATA;
            busy_q  <= 1'b1;
          end
        end

        BUSY_DATA: begin
          // FRAME_END wins over a coincident FRAME_ABORT.
          if (FRAME_END) begin
            state_q     <= EMPTY;
            busy_q      <= 1'b0;
            tx_word_q   <= IDLE_WORD;
            ack_q       <= 4'b0001 << grant_q;
            rr_ptr_q    <= grant_q;
            frame_cnt_q <= sat_inc(frame_cnt_q);
          end else if (FRAME_ABORT) begin
            // Word stays staged for retransmission; arbitration untouched.
            state_q     <= STAGED;
            busy_q      <= 1'b0;
            abort_cnt_q <= sat_inc(abort_cnt_q);
          end
        end

        BUSY_IDLE: begin
          if (FRAME_END) begin
            state_q        <= EMPTY;
            busy_q         <= 1'b0;
            underrun_cnt_q <= sat_inc(underrun_cnt_q);
          end else if (FRAME_ABORT) begin
            state_q     <= EMPTY;
            busy_q      <= 1'b0;
            abort_cnt_q <= sat_inc(abort_cnt_q);
          end
        end

        default: begin
          state_q   <= EMPTY;
          busy_q    <= 1'b0;
          tx_word_q <= IDLE_WORD;
        end
      endcase
    end
  end

  assign REQ_ACK      = ack_q[NCH-1:0];
  assign TX_WORD      = tx_word_q;
  assign BUSY         = busy_q;
  assign FRAME_CNT    = frame_cnt_q;
  assign UNDERRUN_CNT = underrun_cnt_q;
  assign ABORT_CNT    = abort_cnt_q;
  assign PROTO_ERR    = proto_err_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
module tb_spi_tx_scheduler;

  localparam int          NCH  = 4;
  localparam logic [31:0] IDLE = 32'h0000_5A5A;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    req_valid;
  logic [NCH*29-1:0] req_data;
  logic [NCH-1:0]    req_ack;
  logic              frame_start;
  logic              frame_end;
  logic              frame_abort;
  logic [31:0]       tx_word;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [15:0]       underrun_cnt;
  logic [15:0]       abort_cnt;
  logic              proto_err;
  logic              err_clr;

  int total = 0;
  int bad   = 0;

  spi_tx_scheduler #(.NCH(NCH), .IDLE_WORD(IDLE)) dut (
    .CLK          (clk),
    .RST          (rst),
    .REQ_VALID    (req_valid),
    .REQ_DATA     (req_data),
    .REQ_ACK      (req_ack),
    .FRAME_START  (frame_start),
    .FRAME_END    (frame_end),
    .FRAME_ABORT  (frame_abort),
    .TX_WORD      (tx_word),
    .BUSY         (busy),
    .FRAME_CNT    (frame_cnt),
    .UNDERRUN_CNT (underrun_cnt),
    .ABORT_CNT    (abort_cnt),
    .PROTO_ERR    (proto_err),
    .ERR_CLR      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [28:0] d0;
    logic        fs;
    logic        fe;
    logic        fa;
    logic        clr;
    logic [31:0] exp_tx;
    logic [3:0]  exp_ack;
    logic        exp_busy;
    logic        exp_perr;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [28:0] d,
                              input logic s, input logic e, input logic a, input logic c,
                              input logic [31:0] tx, input logic [3:0] ack,
                              input logic b, input logic pe);
    vec_t t;
    t.rst = r; t.valid = v; t.d0 = d; t.fs = s; t.fe = e; t.fa = a; t.clr = c;
    t.exp_tx = tx; t.exp_ack = ack; t.exp_busy = b; t.exp_perr = pe;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic cyc(input logic r, input logic [3:0] v, input logic s,
                     input logic e, input logic a, input logic c);
    @(negedge clk);
    rst = r; req_valid = v; frame_start = s; frame_end = e; frame_abort = a; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [28:0] d);
    req_data[29*ch +: 29] = d;
  endtask

  initial begin
    logic [1:0] prev_ch;
    int         acks [4];
    logic [31:0] exp_w;
    int          ch;

    rst = 1'b1; req_valid = '0; req_data = '0;
    frame_start = 1'b0; frame_end = 1'b0; frame_abort = 1'b0; err_clr = 1'b0;

    // Reset, single request/frame, then three idle frames and an error flag.
    tbl[0]  = mk(1'b1, 4'b0000, 29'h0,        1'b0, 1'b0, 1'b0, 1'b0, IDLE,          4'b0000, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 4'b0001, 29'h0ABC_DEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80AB_CDEF, 4'b0000, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'b0001, 29'h0ABC_DEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80AB_CDEF, 4'b0000, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 4'b0001, 29'h0ABC_DEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80AB_CDEF, 4'b0000, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 4'b0001, 29'h0ABC_DEF, 1'b0, 1'b1, 1'b0, 1'b0, IDLE,          4'b0001, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 4'b0000, 29'h0,        1'b0, 1'b0, 1'b0, 1'b0, IDLE,          4'b0000, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 4'b0000, 29'h0,        1'b1, 1'b0, 1'b0, 1'b0, IDLE,          4'b0000, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 4'b0000, 29'h0,        1'b0, 1'b1, 1'b0, 1'b0, IDLE,          4'b0000, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 4'b0000, 29'h0,        1'b1, 1'b0, 1'b0, 1'b0, IDLE,          4'b0000, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 4'b0000, 29'h0,        1'b0, 1'b1, 1'b0, 1'b0, IDLE,          4'b0000, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 4'b0000, 29'h0,        1'b1, 1'b0, 1'b0, 1'b0, IDLE,          4'b0000, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 4'b0000, 29'h0,        1'b0, 1'b1, 1'b0, 1'b0, IDLE,          4'b0000, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 4'b0000, 29'h0,        1'b0, 1'b1, 1'b0, 1'b0, IDLE,          4'b0000, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 4'b0000, 29'h0,        1'b0, 1'b0, 1'b0, 1'b1, IDLE,          4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      req_data[28:0] = tbl[i].d0;
      cyc(tbl[i].rst, tbl[i].valid, tbl[i].fs, tbl[i].fe, tbl[i].fa, tbl[i].clr);
      chk($sformatf("vec%0d_tx", i),   tx_word,         tbl[i].exp_tx);
      chk($sformatf("vec%0d_ack", i),  32'(req_ack),    32'(tbl[i].exp_ack));
      chk($sformatf("vec%0d_busy", i), 32'(busy),       32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_perr", i), 32'(proto_err),  32'(tbl[i].exp_perr));
    end
    chk("tbl_frame_cnt",    32'(frame_cnt),    32'd1);
    chk("tbl_underrun_cnt", 32'(underrun_cnt), 32'd3);
    chk("tbl_abort_cnt",    32'(abort_cnt),    32'd0);

    // Round-robin with all four channels continuously requesting.
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rr_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    for (int c = 0; c < 4; c++) begin
      set_data(c, 29'h1500_0000 | 29'(c));
      acks[c] = 0;
    end
    prev_ch = 2'd3;
    for (int f = 0; f < 8; f++) begin
      ch    = f % 4;
      exp_w = {1'b1, 2'(ch), 29'h1500_0000 | 29'(ch)};
      cyc(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rr%0d_tx", f), tx_word, exp_w);
      chk($sformatf("rr%0d_ack0", f), 32'(req_ack), 32'd0);
      if (tx_word[30:29] == prev_ch) chk($sformatf("rr%0d_repeat", f), 32'(tx_word[30:29]), 32'(prev_ch + 2'd1));
      prev_ch = tx_word[30:29];
      cyc(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rr%0d_busy", f), 32'(busy), 32'd1);
      cyc(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("rr%0d_ack", f), 32'(req_ack), 32'(4'b0001 << ch));
      for (int c = 0; c < 4; c++) if (req_ack[c]) acks[c]++;
    end
    for (int c = 0; c < 4; c++) chk($sformatf("rr_acks_ch%0d", c), 32'(acks[c]), 32'd2);
    chk("rr_frame_cnt", 32'(frame_cnt), 32'd8);

    // Abort during a data frame keeps the word for retransmission.
    cyc(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    req_data = '0;
    set_data(2, 29'h123_4567);
    cyc(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ab_stage_tx", tx_word, 32'hC123_4567);
    set_data(2, 29'h0FF_FFFF);
    cyc(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ab_hold_tx", tx_word, 32'hC123_4567);
    cyc(1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ab_tx", tx_word, 32'hC123_4567);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ack", 32'(req_ack), 32'd0);
    chk("ab_cnt", 32'(abort_cnt), 32'd1);
    cyc(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ab_restart_busy", 32'(busy), 32'd1);
    cyc(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ab_ack2", 32'(req_ack), 32'b0100);
    chk("ab_frame_cnt", 32'(frame_cnt), 32'd1);

    // Protocol errors, clear, and coincident end/abort.
    set_data(0, 29'h000_0123);
    cyc(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pe_stage_tx", tx_word, 32'h8000_0123);
    cyc(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pe_set", 32'(proto_err), 32'd1);
    chk("pe_busy", 32'(busy), 32'd1);
    chk("pe_tx", tx_word, 32'h8000_0123);
    cyc(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pe_clr", 32'(proto_err), 32'd0);
    chk("pe_clr_busy", 32'(busy), 32'd1);
    cyc(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pe_endab_ack", 32'(req_ack), 32'b0001);
    chk("pe_endab_fcnt", 32'(frame_cnt), 32'd2);
    chk("pe_endab_acnt", 32'(abort_cnt), 32'd1);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pe_win", 32'(proto_err), 32'd1);
    chk("pe_win_tx", tx_word, IDLE);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pe_clr2", 32'(proto_err), 32'd0);

    // Reset in the middle of a data frame.
    set_data(3, 29'h000_0777);
    cyc(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rs_stage_tx", tx_word, 32'hE000_0777);
    cyc(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rs_busy", 32'(busy), 32'd1);
    cyc(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rs_tx", tx_word, IDLE);
    chk("rs_busy0", 32'(busy), 32'd0);
    chk("rs_ack", 32'(req_ack), 32'd0);
    chk("rs_fcnt", 32'(frame_cnt), 32'd0);
    chk("rs_acnt", 32'(abort_cnt), 32'd0);
    chk("rs_ucnt", 32'(underrun_cnt), 32'd0);
    cyc(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rs_restage_tx", tx_word, 32'hE000_0777);
    chk("rs_restage_ack", 32'(req_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
